// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory bus (req/gnt/rvalid) between fetch_ctrl and memory
//
// master : fetch_ctrl  (drives ibus_req_o, ibus_addr_o)
// slave  : memory side (drives ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i)
interface fetch_ctrl_if;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;

   modport master (
      output ibus_req_o,
      output ibus_addr_o,
      input  ibus_gnt_i,
      input  ibus_rvalid_i,
      input  ibus_rdata_i
   );

   modport slave (
      input  ibus_req_o,
      input  ibus_addr_o,
      output ibus_gnt_i,
      output ibus_rvalid_i,
      output ibus_rdata_i
   );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with redirect and one-entry output register
//
// clk, rst_n       : clock, synchronous active-low reset
// jump_en_i        : redirect pulse from ctrl, target jump_addr_i (bits [1:0] forced 0)
// stall_i          : decode cannot accept; inst_* outputs hold
// ibus             : single-outstanding req/gnt/rvalid fetch bus (master side)
// inst_valid_o     : inst_o / inst_addr_o hold a valid instruction
// inst_o           : instruction to decode (NOP_INST when not valid)
// inst_addr_o      : address of inst_o
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               jump_en_i,
   input  logic [31:0]        jump_addr_i,
   input  logic               stall_i,
   fetch_ctrl_if.master       ibus,
   output logic               inst_valid_o,
   output logic [31:0]        inst_o,
   output logic [31:0]        inst_addr_o
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        discard;
   logic [31:0] hold_data;
   logic [31:0] hold_addr;

   logic        consume;
   logic        out_free;
   logic [31:0] jump_target;
   logic        unused_jump_lsb;

   assign jump_target     = {jump_addr_i[31:2], 2'b00};
   assign unused_jump_lsb = ^jump_addr_i[1:0];

   assign consume  = inst_valid_o && !stall_i;
   assign out_free = !inst_valid_o || consume;

   // A stalled valid entry blocks new requests; rst_n gates req so nothing is
   // issued while reset is held, whatever state the registers are in.
   assign ibus.ibus_req_o  = rst_n && (state == S_REQ) && !(inst_valid_o && stall_i);
   assign ibus.ibus_addr_o = pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_REQ;
         pc           <= RESET_PC;
         discard      <= 1'b0;
         hold_data    <= NOP_INST;
         hold_addr    <= 32'h0;
         inst_valid_o <= 1'b0;
         inst_o       <= NOP_INST;
         inst_addr_o  <= 32'h0;
      end else if (jump_en_i) begin
         pc           <= jump_target;
         inst_valid_o <= 1'b0;
         inst_o       <= NOP_INST;
         unique case (state)
            S_REQ: begin
               // A fetch granted this very cycle belongs to the old stream.
               if (ibus.ibus_req_o && ibus.ibus_gnt_i) begin
                  state   <= S_WAIT;
                  discard <= 1'b1;
               end else begin
                  state   <= S_REQ;
               end
            end
            S_WAIT: begin
               if (ibus.ibus_rvalid_i) begin
                  state   <= S_REQ;
                  discard <= 1'b0;
               end else begin
                  discard <= 1'b1;
               end
            end
            default: begin
               state <= S_REQ;
            end
         endcase
      end else begin
         if (consume) begin
            inst_valid_o <= 1'b0;
            inst_o       <= NOP_INST;
         end
         unique case (state)
            S_REQ: begin
               if (ibus.ibus_req_o && ibus.ibus_gnt_i) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (ibus.ibus_rvalid_i) begin
                  if (discard) begin
                     discard <= 1'b0;
                     state   <= S_REQ;
                  end else if (out_free) begin
                     inst_valid_o <= 1'b1;
                     inst_o       <= ibus.ibus_rdata_i;
                     inst_addr_o  <= pc;
                     pc           <= pc + 32'd4;
                     state        <= S_REQ;
                  end else begin
                     hold_data <= ibus.ibus_rdata_i;
                     hold_addr <= pc;
                     pc        <= pc + 32'd4;
                     state     <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (out_free) begin
                  inst_valid_o <= 1'b1;
                  inst_o       <= hold_data;
                  inst_addr_o  <= hold_addr;
                  state        <= S_REQ;
               end
            end
            default: begin
               state <= S_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] KEY  = 32'hA5A5_0000;

   logic        clk;
   logic        rst_n;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        stall;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_addr;

   logic        w_rst_n;
   logic        w_valid;
   logic [31:0] w_inst;
   logic [31:0] w_iaddr;

   fetch_ctrl_if bus();
   fetch_ctrl_if wbus();

   fetch_ctrl u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .jump_en_i    (jump_en),
      .jump_addr_i  (jump_addr),
      .stall_i      (stall),
      .ibus         (bus),
      .inst_valid_o (inst_valid),
      .inst_o       (inst),
      .inst_addr_o  (inst_addr)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk          (clk),
      .rst_n        (w_rst_n),
      .jump_en_i    (1'b0),
      .jump_addr_i  (32'h0),
      .stall_i      (1'b0),
      .ibus         (wbus),
      .inst_valid_o (w_valid),
      .inst_o       (w_inst),
      .inst_addr_o  (w_iaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_gnt = 32'h0;

   typedef struct {
      logic        rst_n;
      logic        gnt;
      logic        rvalid;
      logic        stall;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_iaddr;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic req, input logic [31:0] addr,
                          input logic valid, input logic [31:0] iaddr);
      chk({nm, ".req"},   {31'h0, bus.ibus_req_o}, {31'h0, req});
      chk({nm, ".addr"},  bus.ibus_addr_o, addr);
      chk({nm, ".valid"}, {31'h0, inst_valid}, {31'h0, valid});
      if (valid) begin
         chk({nm, ".iaddr"}, inst_addr, iaddr);
         chk({nm, ".inst"},  inst, mem_f(iaddr));
      end else begin
         chk({nm, ".inst"},  inst, NOP);
      end
   endtask

   // One cycle: drive inputs just after the edge, let outputs settle mid-cycle.
   task automatic step(input logic r, input logic g, input logic v, input logic s,
                       input logic j, input logic [31:0] ja);
      @(posedge clk);
      #1;
      rst_n              = r;
      bus.ibus_gnt_i     = g;
      bus.ibus_rvalid_i  = v;
      bus.ibus_rdata_i   = mem_f(last_gnt);
      stall              = s;
      jump_en            = j;
      jump_addr          = ja;
      #4;
      if (bus.ibus_req_o && g) last_gnt = bus.ibus_addr_o;
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
   endtask

   logic        pending;
   logic [31:0] paddr;
   int          dly;
   logic [31:0] next_exp;
   int          deliv;
   logic        prev_hold, prev_req_wait;
   logic [31:0] prev_inst, prev_iaddr, prev_addr;
   logic        g, s, j, rv;
   logic [31:0] ja;
   logic [31:0] wexp [4];
   logic [31:0] w_last;

   initial begin
      rst_n = 0; jump_en = 0; jump_addr = 0; stall = 0;
      bus.ibus_gnt_i = 0; bus.ibus_rvalid_i = 0; bus.ibus_rdata_i = 0;
      w_rst_n = 0; wbus.ibus_gnt_i = 1; wbus.ibus_rvalid_i = 0; wbus.ibus_rdata_i = 0;

      // Reset release and steady-state fetch: rst, gnt, rvalid, stall | req, addr, valid, iaddr
      vecs[0] = '{0, 0, 0, 0, 0, 32'h00, 0, 32'h0};
      vecs[1] = '{1, 1, 0, 0, 1, 32'h00, 0, 32'h0};
      vecs[2] = '{1, 1, 1, 0, 0, 32'h00, 0, 32'h0};
      vecs[3] = '{1, 1, 0, 0, 1, 32'h04, 1, 32'h0};
      vecs[4] = '{1, 1, 1, 0, 0, 32'h04, 0, 32'h0};
      vecs[5] = '{1, 1, 0, 0, 1, 32'h08, 1, 32'h4};
      vecs[6] = '{1, 1, 1, 0, 0, 32'h08, 0, 32'h4};
      vecs[7] = '{1, 1, 0, 0, 1, 32'h0C, 1, 32'h8};
      vecs[8] = '{1, 1, 1, 0, 0, 32'h0C, 0, 32'h8};
      vecs[9] = '{1, 0, 0, 0, 1, 32'h10, 1, 32'hC};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].rst_n, vecs[i].gnt, vecs[i].rvalid, vecs[i].stall, 0, 0);
         chk_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                 vecs[i].exp_valid, vecs[i].exp_iaddr);
      end

      // Stall while 0x4 is presented: outputs frozen, no requests issued.
      do_reset();
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 0, 1, 0, 0);
         chk_out($sformatf("stall%0d", i), 0, 32'h8, 1, 32'h4);
      end
      step(1, 1, 0, 0, 0, 0);
      chk_out("stall_rel", 1, 32'h8, 1, 32'h4);
      step(1, 0, 1, 0, 0, 0);
      chk_out("stall_wait", 0, 32'h8, 0, 32'h4);
      step(1, 0, 0, 0, 0, 0);
      chk_out("stall_next", 1, 32'hC, 1, 32'h8);

      // Redirect coincident with gnt for 0x8: its response is dropped.
      do_reset();
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 1, 32'h103);
      step(1, 0, 1, 0, 0, 0);
      chk_out("jg_drop", 0, 32'h100, 0, 32'h0);
      step(1, 1, 0, 0, 0, 0);
      chk_out("jg_req", 1, 32'h100, 0, 32'h0);
      step(1, 0, 1, 0, 0, 0);
      chk_out("jg_wait", 0, 32'h100, 0, 32'h0);
      step(1, 1, 0, 0, 0, 0);
      chk_out("jg_valid", 1, 32'h104, 1, 32'h100);

      // Redirect coincident with rvalid: data dropped, flushed to NOP.
      step(1, 0, 1, 0, 1, 32'h200);
      step(1, 1, 0, 0, 0, 0);
      chk_out("jr_req", 1, 32'h200, 0, 32'h0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk_out("jr_valid", 1, 32'h204, 1, 32'h200);

      // gnt withheld, redirect during the wait.
      step(1, 0, 0, 0, 0, 0);
      chk_out("gw_hold1", 1, 32'h204, 0, 32'h0);
      step(1, 0, 0, 0, 1, 32'h300);
      chk_out("gw_hold2", 1, 32'h204, 0, 32'h0);
      step(1, 1, 0, 0, 0, 0);
      chk_out("gw_redir", 1, 32'h300, 0, 32'h0);
      step(1, 0, 1, 0, 0, 0);
      chk_out("gw_wait", 0, 32'h300, 0, 32'h0);
      step(1, 1, 0, 0, 0, 0);
      chk_out("gw_valid", 1, 32'h304, 1, 32'h300);

      // Reset during S_WAIT, then a late rvalid that must be ignored.
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_out("rst_mid", 0, 32'h0, 0, 32'h0);
      chk("rst_mid.iaddr", inst_addr, 32'h0);
      step(1, 0, 1, 0, 0, 0);
      chk_out("late_rv", 1, 32'h0, 0, 32'h0);
      step(1, 0, 0, 0, 0, 0);
      chk_out("late_rv2", 1, 32'h0, 0, 32'h0);

      // Address wrap with RESET_PC = FFFF_FFF8.
      wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC;
      wexp[2] = 32'h0000_0000; wexp[3] = 32'h0000_0004;
      w_last = 32'h0;
      @(posedge clk); @(posedge clk);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
         w_rst_n            = 1;
         wbus.ibus_rvalid_i = (i % 2 == 1);
         wbus.ibus_rdata_i  = mem_f(w_last);
         #4;
         if (wbus.ibus_req_o) w_last = wbus.ibus_addr_o;
         if (i % 2 == 0) begin
            chk($sformatf("wrap_addr%0d", i), wbus.ibus_addr_o, wexp[i/2]);
            chk($sformatf("wrap_req%0d", i), {31'h0, wbus.ibus_req_o}, 32'h1);
            if (i >= 2) begin
               chk($sformatf("wrap_iaddr%0d", i), w_iaddr, wexp[i/2-1]);
               chk($sformatf("wrap_inst%0d", i), w_inst, mem_f(wexp[i/2-1]));
            end
         end
      end

      // Randomized traffic against a stream-level reference.
      do_reset();
      pending = 0; paddr = 0; dly = 0; next_exp = 0; deliv = 0;
      prev_hold = 0; prev_req_wait = 0; prev_inst = 0; prev_iaddr = 0; prev_addr = 0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         g  = ($urandom_range(3) != 0);
         s  = ($urandom_range(2) == 0);
         j  = ($urandom_range(11) == 0);
         ja = $urandom;
         rv = pending && (dly == 0);
         rst_n             = 1;
         bus.ibus_gnt_i    = g;
         bus.ibus_rvalid_i = rv;
         bus.ibus_rdata_i  = mem_f(paddr);
         stall             = s;
         jump_en           = j;
         jump_addr         = ja;
         #4;
         if (rv) pending = 0;
         else if (pending) dly--;
         if (!inst_valid) chk("rnd_nop", inst, NOP);
         if (prev_hold) begin
            chk("rnd_hold_valid", {31'h0, inst_valid}, 32'h1);
            chk("rnd_hold_inst", inst, prev_inst);
            chk("rnd_hold_iaddr", inst_addr, prev_iaddr);
         end
         if (prev_req_wait) chk("rnd_req_stable", bus.ibus_addr_o, prev_addr);
         if (bus.ibus_req_o && g) begin
            chk("rnd_one_outstanding", {31'h0, pending}, 32'h0);
            pending = 1;
            paddr   = bus.ibus_addr_o;
            dly     = $urandom_range(2);
         end
         if (inst_valid && !s) begin
            chk("rnd_order", inst_addr, next_exp);
            chk("rnd_data", inst, mem_f(inst_addr));
            next_exp = next_exp + 32'd4;
            deliv++;
         end
         if (j) next_exp = {ja[31:2], 2'b00};
         prev_hold     = inst_valid && s && !j;
         prev_inst     = inst;
         prev_iaddr    = inst_addr;
         prev_req_wait = bus.ibus_req_o && !g && !j;
         prev_addr     = bus.ibus_addr_o;
      end
      chk("rnd_progress", {31'h0, deliv >= 150}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
